tim_etb_trig_sched: RTL

Scheduler that serialises timer start/stop commands from several requesters (ETB channels, DMA, software shim) onto the four one-cycle trigger-enable inputs of the dual-timer block (timer 1 on/off, timer 2 on/off). It runs a round-robin arbiter with a valid/ready handshake and enforces a minimum idle gap between issued triggers. It tracks the running state of both timers and suppresses redundant commands. Optionally, it chains timer 2 start onto the timer 1 expiry trigger. It sits in the timer subsystem between the requesters and the timer top level, in the pclk domain.

---
 rtl/tim_sched_pkg.sv | 30 +++
 rtl/tim_etb_trig_sched_if.sv | 23 ++
 rtl/tim_sched_rr_arb.sv | 30 +++
 rtl/tim_etb_trig_sched.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/tim_sched_pkg.sv
// Shared types and constants for the timer trigger scheduler.
// Command encoding is {tsel, on}; tsel 0=timer1, 1=timer2.
package tim_sched_pkg;

  localparam int TSEL = 1;
  localparam int ON = 0;
  localparam logic [1:0] CMD_T2_START = 2'b11;
  localparam int GCW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_e;

  // One-hot trigger vector {t2_off, t2_on, t1_off, t1_on}
  function automatic logic [3:0] trig_dec(input logic [1:0] cmd);
    logic [3:0] t;
    t = 4'b0000;
    case (cmd)
      2'b01: t = 4'b0001;
      2'b00: t = 4'b0010;
      2'b11: t = 4'b0100;
      2'b10: t = 4'b1000;
      default: t = 4'b0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tim_etb_trig_sched_if.sv
// Requester-side command handshake bundle.
// Each requester holds vld/cmd until its one-cycle rdy pulse.
interface tim_etb_trig_sched_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]   req_vld;
  logic [2*NREQ-1:0] req_cmd;
  logic [NREQ-1:0]   req_rdy;

  modport master (
    output req_vld,
    output req_cmd,
    input  req_rdy
  );

  modport slave (
    input  req_vld,
    input  req_cmd,
    output req_rdy
  );

endinterface

// File: rtl/tim_sched_rr_arb.sv
// Round-robin arbiter: search starts at ptr and wraps upward.
// Purely combinational; the caller owns the pointer.
module tim_sched_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  always_comb begin
    int k;
    k = 0;
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!any && req[k]) begin
        any = 1'b1;
        gnt_idx = IW'(k);
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/tim_etb_trig_sched.sv
// Serialises timer start/stop commands onto the dual-timer trigger
// inputs, with idle gap, redundancy suppression and timer2 chaining.
module tim_etb_trig_sched
  import tim_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GAP = 2
) (
  input  logic       pclk,
  input  logic       preset,
  tim_etb_trig_sched_if.slave req,
  input  logic       chain_en,
  input  logic       tim1_etb_trig,
  output logic       etb_tim1_trig_en_on,
  output logic       etb_tim1_trig_en_off,
  output logic       etb_tim2_trig_en_on,
  output logic       etb_tim2_trig_en_off,
  output logic [1:0] tim_run,
  output logic       busy
);

  localparam int IW = $clog2(NREQ);
  localparam logic [GCW-1:0] GAP_LD =
    (GAP > 0) ? GCW'(GAP - 1) : '0;

  state_e state, state_nxt;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rdy_d;
  logic [NREQ-1:0] rdy_q;
  logic            any;
  logic            take;
  logic            eff_q;
  logic            chain_pend;
  logic            pend_nxt;
  logic            sel_eff;
  logic            busy_d;
  logic [1:0]      cmd_q;
  logic [1:0]      win_cmd;
  logic [1:0]      sel_cmd;
  logic [1:0]      run_eff;
  logic [1:0]      run_nxt;
  logic [3:0]      trig_d;
  logic [3:0]      trig_q;
  logic [GCW-1:0]  cnt;

  tim_sched_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .req    (req.req_vld),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_idx(win_idx),
    .any    (any)
  );

  assign win_cmd = req.req_cmd[{win_idx, 1'b0} +: 2];

  // Expiry in the decision cycle must count, else a restart looks redundant
  assign run_eff = {tim_run[1], tim_run[0] & ~tim1_etb_trig};
  assign sel_cmd = chain_pend ? CMD_T2_START : win_cmd;
  assign sel_eff = sel_cmd[ON] != run_eff[sel_cmd[TSEL]];
  assign take = (state == S_IDLE) && (chain_pend || any);
  assign pend_nxt = (chain_en && tim1_etb_trig)
                 || (chain_pend && state != S_IDLE);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (chain_pend || any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (eff_q && GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdy_d = '0;
    trig_d = '0;
    if (take && !chain_pend) rdy_d = gnt;
    if (take && sel_eff) trig_d = trig_dec(sel_cmd);
    busy_d = (state_nxt != S_IDLE) || pend_nxt;
  end

  // A set from ISSUE overrides a same-cycle expiry clear
  always_comb begin
    run_nxt = run_eff;
    if (state == S_ISSUE && eff_q) run_nxt[cmd_q[TSEL]] = cmd_q[ON];
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ptr <= '0;
      cmd_q <= '0;
      eff_q <= 1'b0;
      chain_pend <= 1'b0;
      cnt <= '0;
      tim_run <= '0;
    end else begin
      chain_pend <= pend_nxt;
      tim_run <= run_nxt;
      if (take) begin
        cmd_q <= sel_cmd;
        eff_q <= sel_eff;
      end
      if (take && !chain_pend)
        ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      if (state == S_ISSUE)
        cnt <= GAP_LD;
      else if (state == S_GAP && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rdy_q <= '0;
      trig_q <= '0;
      busy <= 1'b0;
    end else begin
      rdy_q <= rdy_d;
      trig_q <= trig_d;
      busy <= busy_d;
    end
  end

  assign req.req_rdy = rdy_q;
  assign etb_tim1_trig_en_on = trig_q[0];
  assign etb_tim1_trig_en_off = trig_q[1];
  assign etb_tim2_trig_en_on = trig_q[2];
  assign etb_tim2_trig_en_off = trig_q[3];

endmodule
